// File: rtl/uvmt_reset_st_multi_clk_gen_pkg.sv
// Shared types and default widths for the multi-channel clock/reset generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uvmt_reset_st_multi_clk_gen_pkg;

    // Per-channel sequencing state
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RST_PHASE = 2'd1,
        ST_RUN       = 2'd2,
        ST_STOPPING  = 2'd3
    } ch_state_t;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_RST_W  = 8;
    localparam int DEF_HALF   = 5;
    localparam int DEF_RST    = 4;

endpackage

// File: rtl/uvmt_reset_st_clk_gen_ch.sv
// One clock/reset channel: divided clock with programmable half-period and reset-held cycle count.
// Latency: start sampled at edge N -> first clk_out rise at N+H; rst_out falls with clk_out at N+2RH.
// Backpressure: config only accepted while idle (idle output); start ignored when busy, stop wins over start.
//
// Ports:
//   clk, reset           master clock, synchronous active-high reset
//   cfg_we               write cfg_half/cfg_rst into this channel's config registers
//   cfg_half, cfg_rst    half-period (master cycles) and reset-held rising-edge count
//   start, stop          single-cycle control pulses
//   clk_out, rst_out     registered divided clock and active-high channel reset
//   running              channel in RUN
//   idle                 channel in IDLE (drives the top-level cfg_ready mux)
module uvmt_reset_st_clk_gen_ch
    import uvmt_reset_st_multi_clk_gen_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_W        = DEF_RST_W,
    parameter int DEFAULT_HALF = DEF_HALF,
    parameter int DEFAULT_RST  = DEF_RST
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_half,
    input  logic [RST_W-1:0] cfg_rst,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             rst_out,
    output logic             running,
    output logic             idle
);

    ch_state_t        state;
    logic [CNT_W-1:0] half_cfg;
    logic [RST_W-1:0] rst_cfg;
    // Active copies latched at start, so a config write in the same cycle
    // as start only affects the next run.
    logic [CNT_W-1:0] half_act;
    logic [RST_W-1:0] rst_act;
    logic [CNT_W-1:0] cnt;
    logic [RST_W-1:0] rise_cnt;
    logic             toggle;
    logic [CNT_W-1:0] half_eff;

    assign toggle   = (cnt == half_act - CNT_W'(1));
    assign half_eff = (half_cfg == '0) ? CNT_W'(1) : half_cfg;
    assign idle     = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            half_cfg <= CNT_W'(DEFAULT_HALF);
            rst_cfg  <= RST_W'(DEFAULT_RST);
            half_act <= CNT_W'(1);
            rst_act  <= '0;
            cnt      <= '0;
            rise_cnt <= '0;
            clk_out  <= 1'b0;
            rst_out  <= 1'b1;
            running  <= 1'b0;
        end else begin
            if (cfg_we) begin
                half_cfg <= cfg_half;
                rst_cfg  <= cfg_rst;
            end

            case (state)
                ST_IDLE: begin
                    cnt     <= '0;
                    clk_out <= 1'b0;
                    rst_out <= 1'b1;
                    running <= 1'b0;
                    if (start && !stop) begin
                        half_act <= half_eff;
                        rst_act  <= rst_cfg;
                        rise_cnt <= '0;
                        if (rst_cfg == '0) begin
                            state   <= ST_RUN;
                            rst_out <= 1'b0;
                            running <= 1'b1;
                        end else begin
                            state <= ST_RST_PHASE;
                        end
                    end
                end

                ST_RST_PHASE, ST_RUN: begin
                    cnt <= toggle ? '0 : cnt + CNT_W'(1);
                    if (toggle) begin
                        clk_out <= ~clk_out;
                    end
                    if (stop) begin
                        running <= 1'b0;
                        rst_out <= 1'b1;
                        // Low now, or falling this very edge: stop without
                        // shortening any high phase.
                        if (!clk_out || toggle) begin
                            state   <= ST_IDLE;
                            clk_out <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            state <= ST_STOPPING;
                        end
                    end else if (state == ST_RST_PHASE && toggle) begin
                        if (!clk_out) begin
                            rise_cnt <= rise_cnt + RST_W'(1);
                        end else if (rise_cnt == rst_act) begin
                            // Falling toggle after the last counted rise
                            state   <= ST_RUN;
                            rst_out <= 1'b0;
                            running <= 1'b1;
                        end
                    end
                end

                ST_STOPPING: begin
                    cnt <= toggle ? '0 : cnt + CNT_W'(1);
                    if (toggle) begin
                        clk_out <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uvmt_reset_st_multi_clk_gen.sv
// N-channel clock/reset generator: config write decode and cfg_ready mux over independent channels.
// Latency: config write lands on the next edge; channel timing is set by each channel.
// Backpressure: cfg_ready (combinational) is low while the addressed channel is not idle.
//
// Ports:
//   clk, reset                    master clock, synchronous active-high reset
//   cfg_valid/cfg_ready           config write handshake for channel cfg_ch
//   cfg_ch, cfg_half, cfg_rst     target channel, half-period, reset-held edge count
//   start, stop                   per-channel control pulses
//   clk_out, rst_out, running     per-channel outputs
module uvmt_reset_st_multi_clk_gen
    import uvmt_reset_st_multi_clk_gen_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_W        = DEF_RST_W,
    parameter int DEFAULT_HALF = DEF_HALF,
    parameter int DEFAULT_RST  = DEF_RST,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    input  logic [RST_W-1:0]  cfg_rst,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] rst_out,
    output logic [NUM_CH-1:0] running
);

    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] cfg_we;

    // An out-of-range cfg_ch (non power-of-two NUM_CH) is never ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = idle[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign cfg_we[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        uvmt_reset_st_clk_gen_ch #(
            .CNT_W        (CNT_W),
            .RST_W        (RST_W),
            .DEFAULT_HALF (DEFAULT_HALF),
            .DEFAULT_RST  (DEFAULT_RST)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (cfg_we[g]),
            .cfg_half (cfg_half),
            .cfg_rst  (cfg_rst),
            .start    (start[g]),
            .stop     (stop[g]),
            .clk_out  (clk_out[g]),
            .rst_out  (rst_out[g]),
            .running  (running[g]),
            .idle     (idle[g])
        );
    end

endmodule

// File: doc/uvmt_reset_st_multi_clk_gen.md
# uvmt_reset_st_multi_clk_gen

Synthesisable, parametrised N-channel clock and reset generator for the Reset VIP self-test bench. Each channel derives a divided clock from the bench master clock, with a programmable half-period and a programmable count of reset-held clock cycles. Each channel also sequences start, reset release and glitch-free stop. The block replaces ad-hoc per-test clock drivers; its outputs feed the DUT and agent interfaces.

## Interface
- NUM_CH, 4, number of independent output channels (1..16)
- CNT_W, 16, width of half-period counter/config
- RST_W, 8, width of reset-cycle counter/config
- DEFAULT_HALF, 5, reset value of every channel's half-period
- DEFAULT_RST, 4, reset value of every channel's reset-cycle count
- clk  in  1  master clock; one clock domain
- reset  in  1  synchronous, active-high reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  high when channel cfg_ch is IDLE (combinational)
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of config write
- cfg_half  in  CNT_W  half-period in master cycles
- cfg_rst  in  RST_W  divided-clock rising edges with rst_out held
- start  in  NUM_CH  per-channel start pulse
- stop  in  NUM_CH  per-channel stop pulse
- clk_out  out  NUM_CH  divided clocks (registered)
- rst_out  out  NUM_CH  active-high channel resets (registered)
- running  out  NUM_CH  channel in RUN state

## Operation
- Per-channel FSM: IDLE, RST_PHASE, RUN, STOPPING.
- Config write is accepted when cfg_valid && cfg_ready. It updates that channel's half/rst registers on the next edge. Writes to busy channels are not accepted.
- Effective half-period H = max(cfg_half, 1). clk_out toggles when the half-counter reaches H-1; the counter then clears. Period = 2H master cycles, 50% duty.
- IDLE + start: counter cleared and clk_out=0. Next state is RST_PHASE, or RUN directly if R=0.
- RST_PHASE: rst_out=1. The block counts clk_out rising edges. After the R-th rising edge, rst_out deasserts on the following clk_out falling toggle, in the same cycle. The state becomes RUN.
- RUN: clk_out free-runs and rst_out=0.
- stop in RST_PHASE or RUN:
  - if clk_out=0, the next state is IDLE;
  - else the state is STOPPING, which finishes the high phase. At the falling toggle, clk_out=0 and the state becomes IDLE.
- rst_out=1 in every state except RUN. running=1 only in RUN.
- start is ignored outside IDLE. stop in IDLE or STOPPING is ignored.
- start and stop in the same cycle: stop wins (start ignored in IDLE).
- A cfg write and a start to the same channel in the same cycle: the write is accepted, but start uses the previous config. The new config applies to the next start.
- Channels are fully independent; no phase alignment between channels.

## Timing
- On reset: all channels IDLE, clk_out=0, rst_out=1, running=0, counters 0, half=DEFAULT_HALF, rst=DEFAULT_RST, cfg_ready=1.
- start sampled at edge N: counter runs from N+1. The first clk_out rise is at edge N+H. rst_out=1 throughout.
- R rising edges at H, 3H, ... (2R-1)H after start. rst_out falls together with clk_out at 2RH after start. running rises in the same cycle.
- stop sampled while clk_out=0: next cycle IDLE, clk_out remains 0, and rst_out=1 one cycle after the sample.
- Outputs never produce a high pulse shorter than H master cycles.
- Reset mid-operation overrides everything: next cycle matches the reset state, and config returns to defaults.
- Counter wrap is impossible, because the counter clears at H-1 ≤ 2^CNT_W-2.

## Structure
- Package uvmt_reset_st_multi_clk_gen_pkg holds:
  - the state enum (IDLE, RST_PHASE, RUN, STOPPING);
  - default-width constants.
- Sub-module uvmt_reset_st_clk_gen_ch holds one channel: config registers, counters, FSM and outputs. It is instantiated NUM_CH times in a generate loop.
- The top holds only the cfg_ch decode and cfg_ready mux.

## Test plan
- Reset, then start ch0 (defaults H=5, R=4):
  - clk_out0 rises at +5 with period 10;
  - rst_out0 falls with clk_out0 at +40;
  - running0 rises at +40.
- cfg ch1 H=1, R=0, then start: clk_out1 toggles every cycle, rst_out1 falls and running1 rises one cycle after start.
- ch2 H=3 in RUN, stop sampled 1 cycle into the high phase → clk_out2 stays high 2 more cycles, then clk_out2=0 and rst_out2=1 in IDLE.
- Simultaneous start+stop on ch3 in IDLE → stays IDLE. cfg write to ch0 while running → cfg_ready=0 and the write is not accepted.
- Same-cycle cfg write (H=7) and start on ch1 → runs with the old H. Stop, then restart → period 14.
- reset asserted mid-RST_PHASE on all channels → next cycle all clk_out=0, rst_out=1, running=0. The next start uses H=5, R=4.
